mem_initiator: RTL and testbench

//  Requester side of the memory_cont rw_req/data_valid protocol. Arbitrates the core's instruction-fetch (IF)
//  and load/store (LS) ports onto the single memory controller, drives a one-cycle rw_req per transaction and

---
 rtl/mem_initiator_pkg.sv | 36 +++
 rtl/mem_initiator_if.sv | 20 ++
 rtl/mem_initiator_load_extend.sv | 22 ++
 rtl/mem_initiator.sv | 176 +++++++++++++++++
 tb/tb_mem_initiator.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the memory requester: transfer size codes, RISC-V load/store
// funct3 codes, FSM states and the load/store legality check.
package mem_initiator_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // True when a load/store must be trapped before reaching the controller.
  function automatic logic ls_check_fail(input logic we, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    case (f3[1:0])
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      default: misaligned = (addr_lo != 2'b00);
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// rw_req/data_valid bus between the requester (master) and the memory controller (slave).
interface mem_initiator_if;
  logic [31:0] mem_address;
  logic        mem_rw_req;
  logic        mem_rw;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_size;
  logic [31:0] mem_read_data;
  logic        mem_data_valid;

  modport master (
    output mem_address, mem_rw_req, mem_rw, mem_write_data, mem_size,
    input  mem_read_data, mem_data_valid
  );

  modport slave (
    input  mem_address, mem_rw_req, mem_rw, mem_write_data, mem_size,
    output mem_read_data, mem_data_valid
  );
endinterface

// File: rtl/mem_initiator_load_extend.sv
// Sign/zero extension of LSB-justified controller read data according to RISC-V load funct3.
module mem_initiator_load_extend
  import mem_initiator_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_W:    data_o = data_i;
      F3_BU:   data_o = {24'd0, data_i[7:0]};
      F3_HU:   data_o = {16'd0, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// Arbitrates instruction-fetch and load/store requests onto one memory controller,
// trapping bad accesses up front and timing out requests that are never answered.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              ls_valid,
  output logic              ls_err,
  mem_initiator_if.master   mem
);

  state_t            state_q, state_d;
  logic              pend_if_q, pend_if_d;
  logic [31:0]       pend_addr_q, pend_addr_d;
  logic              own_ls_q, own_ls_d;
  logic              err_q, err_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       ls_rdata_q, ls_rdata_d;

  logic              ls_bad;
  logic [31:0]       fetch_addr;
  logic              fetch_bad;
  logic [31:0]       ext_data;

  assign ls_bad     = ls_check_fail(ls_we, ls_funct3, ls_addr[1:0]);
  assign fetch_addr = pend_if_q ? pend_addr_q : if_addr;
  assign fetch_bad  = |fetch_addr[1:0];

  mem_initiator_load_extend u_ext (
    .funct3_i (f3_q),
    .data_i   (mem.mem_read_data),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    pend_if_d   = pend_if_q;
    pend_addr_d = pend_addr_q;
    own_ls_d    = own_ls_q;
    err_d       = err_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ls_req) begin
          own_ls_d = 1'b1;
          f3_d     = ls_funct3;
          err_d    = ls_bad;
          state_d  = ls_bad ? ST_RESP : ST_ISSUE;
          // Bus fields only move when a request will actually be issued.
          if (!ls_bad) begin
            addr_d  = ls_addr;
            rw_d    = ls_we;
            size_d  = ls_funct3[1:0];
            wdata_d = ls_wdata;
          end
          if (if_req && !pend_if_q) begin
            pend_if_d   = 1'b1;
            pend_addr_d = if_addr;
          end
        end else if (pend_if_q || if_req) begin
          own_ls_d  = 1'b0;
          f3_d      = F3_W;
          err_d     = fetch_bad;
          pend_if_d = 1'b0;
          state_d   = fetch_bad ? ST_RESP : ST_ISSUE;
          if (!fetch_bad) begin
            addr_d  = fetch_addr;
            rw_d    = 1'b0;
            size_d  = SZ_WORD;
            wdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem.mem_data_valid) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (own_ls_q) ls_rdata_d = rw_q ? 32'd0 : ext_data;
          else          if_rdata_d = mem.mem_read_data;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pend_if_q  <= 1'b0;
      own_ls_q   <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_if_q  <= pend_if_d;
      own_ls_q   <= own_ls_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // Side data qualified by pend_if_q / state, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    f3_q        <= f3_d;
  end

  assign if_ready = (state_q == ST_IDLE) && !pend_if_q;
  assign ls_ready = (state_q == ST_IDLE);
  assign if_valid = (state_q == ST_RESP) && !own_ls_q && !err_q;
  assign if_err   = (state_q == ST_RESP) && !own_ls_q &&  err_q;
  assign ls_valid = (state_q == ST_RESP) &&  own_ls_q && !err_q;
  assign ls_err   = (state_q == ST_RESP) &&  own_ls_q &&  err_q;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;

  assign mem.mem_rw_req     = (state_q == ST_ISSUE);
  assign mem.mem_address    = addr_q;
  assign mem.mem_rw         = rw_q;
  assign mem.mem_size       = size_q;
  assign mem.mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized and directed bench for mem_initiator with a latency-programmable controller model
// and an arithmetic reference for load extension, trap rules and completion timing.
module tb_mem_initiator;

  localparam int TO = 64;

  logic        clk;
  logic        reset;
  logic        if_req, if_ready, if_valid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_ready, ls_valid, ls_err;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;

  mem_initiator_if mb ();

  mem_initiator #(.TIMEOUT_CYCLES(TO), .TO_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_err    (if_err),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_funct3 (ls_funct3),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_ready  (ls_ready),
    .ls_rdata  (ls_rdata),
    .ls_valid  (ls_valid),
    .ls_err    (ls_err),
    .mem       (mb.master)
  );

  int total = 0;
  int bad   = 0;

  int          ctl_lat  = 2;
  logic [31:0] ctl_data = 32'd0;
  logic [31:0] log_addr[$];
  logic        log_rw[$];
  logic [1:0]  log_sz[$];
  logic [31:0] log_wd[$];
  logic [31:0] last_ls = 32'd0;
  logic [31:0] last_if = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Controller model: logs every request, answers after ctl_lat cycles unless addr >= 0x10000.
  initial begin : controller
    int cnt;
    cnt = -1;
    mb.mem_data_valid = 1'b0;
    mb.mem_read_data  = 32'd0;
    forever begin
      @(negedge clk);
      mb.mem_data_valid = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mb.mem_data_valid = 1'b1;
          mb.mem_read_data  = ctl_data;
          cnt = -1;
        end
      end
      if (mb.mem_rw_req === 1'b1) begin
        log_addr.push_back(mb.mem_address);
        log_rw.push_back(mb.mem_rw);
        log_sz.push_back(mb.mem_size);
        log_wd.push_back(mb.mem_write_data);
        if (mb.mem_address < 32'h10000) cnt = ctl_lat;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_bad_ls(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit illegal;
    int nb;
    illegal = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4);
    nb = 1 << (f3 % 4);
    return illegal || ((addr % nb) != 0);
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] raw);
    longint nb, span, v;
    nb   = longint'(1) << (f3 % 4);
    span = longint'(1) << (8 * nb);
    v    = longint'({32'd0, raw}) % span;
    if (f3 < 4 && nb < 4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One isolated transaction on either port, checked end to end.
  task automatic txn(input bit is_ls, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] raw);
    int lat, base, cyc, expcyc;
    bit bad_op, tmo, got;
    logic [31:0] exprd;
    logic [2:0] expctl;
    lat    = $urandom_range(1, 4);
    bad_op = is_ls ? ref_bad_ls(we, f3, addr) : ((addr % 4) != 0);
    tmo    = !bad_op && (addr >= 32'h10000);
    exprd  = is_ls ? (we ? 32'd0 : ref_ext(f3, raw)) : raw;
    expcyc = bad_op ? 1 : (tmo ? 2 + TO : 2 + lat);
    expctl = {we & is_ls, is_ls ? f3[1:0] : 2'd2};
    ctl_lat  = lat;
    ctl_data = raw;
    base     = log_addr.size();
    @(negedge clk);
    chk("ready_before", is_ls ? ls_ready : if_ready, 1);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clk);
    ls_req = 1'b0; if_req = 1'b0;
    ls_addr = $urandom; ls_wdata = $urandom; ls_funct3 = 3'($urandom); ls_we = 1'($urandom);
    if_addr = $urandom;
    cyc = 1;
    got = 0;
    while (!got && cyc < 300) begin
      if (is_ls ? (ls_valid | ls_err) : (if_valid | if_err)) got = 1;
      else begin
        if (!bad_op) begin
          chk("bus_hold_addr", mb.mem_address, addr);
          chk("bus_hold_ctl", {mb.mem_rw, mb.mem_size}, expctl);
        end
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_cycle", cyc, expcyc);
    chk("valid", is_ls ? ls_valid : if_valid, !(bad_op || tmo));
    chk("err", is_ls ? ls_err : if_err, bad_op || tmo);
    if (!(bad_op || tmo)) begin
      chk("rdata", is_ls ? ls_rdata : if_rdata, exprd);
      if (is_ls) last_ls = exprd; else last_if = exprd;
    end
    chk("req_count", log_addr.size() - base, bad_op ? 0 : 1);
    if (!bad_op && log_addr.size() > base) begin
      chk("req_addr", log_addr[base], addr);
      chk("req_rw", log_rw[base], we & is_ls);
      chk("req_size", log_sz[base], expctl[1:0]);
      if (is_ls && we) chk("req_wdata", log_wd[base], wd);
    end
    @(negedge clk);
    chk("one_pulse", {ls_valid, ls_err, if_valid, if_err}, 0);
    chk("ready_after", {ls_ready, if_ready}, 2'b11);
    chk("ls_rdata_hold", ls_rdata, last_ls);
    chk("if_rdata_hold", if_rdata, last_if);
  endtask

  initial begin : main
    int base, ls_at, if_at, nls, nif, nerr, pulses;
    logic [31:0] addr;
    bit we;
    logic [2:0] f3;
    reset = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = 3'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {ls_ready, if_ready}, 2'b11);
    chk("rst_pulses", {ls_valid, ls_err, if_valid, if_err}, 0);
    chk("rst_rw_req", mb.mem_rw_req, 0);
    chk("rst_addr", mb.mem_address, 0);
    chk("rst_ctl", {mb.mem_rw, mb.mem_size}, 0);
    chk("rst_wdata", mb.mem_write_data, 0);
    chk("rst_rdata", ls_rdata | if_rdata, 0);
    reset = 1'b1;

    // Basic word load, then sign/zero extension cases.
    txn(1, 0, 3'b010, 32'h100, 32'd0, 32'h11223344);
    txn(1, 0, 3'b000, 32'h101, 32'd0, 32'h000000F0);
    txn(1, 0, 3'b100, 32'h101, 32'd0, 32'h000000F0);
    txn(1, 0, 3'b001, 32'h102, 32'd0, 32'h00008001);
    txn(1, 0, 3'b101, 32'h102, 32'd0, 32'h00008001);
    txn(1, 1, 3'b000, 32'h103, 32'hA5A5A5A5, 32'd0);
    // Traps: misaligned and illegal funct3.
    txn(1, 0, 3'b010, 32'h102, 32'd0, 32'd0);
    txn(1, 1, 3'b001, 32'h201, 32'h1234, 32'd0);
    txn(1, 0, 3'b011, 32'h100, 32'd0, 32'd0);
    txn(1, 1, 3'b100, 32'h100, 32'd0, 32'd0);
    // Timeout, then normal service.
    txn(1, 0, 3'b010, 32'h20000, 32'd0, 32'd0);
    txn(1, 0, 3'b010, 32'h104, 32'd0, 32'hCAFEF00D);
    txn(0, 0, 3'b000, 32'h400, 32'd0, 32'h00000013);
    txn(0, 0, 3'b000, 32'h402, 32'd0, 32'd0);

    // Simultaneous LS and IF: store first, fetch drains from the pending slot.
    ctl_lat  = 2;
    ctl_data = 32'h00A00093;
    base = log_addr.size();
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h300;
    @(negedge clk);
    ls_req = 1'b0; if_req = 1'b0; ls_addr = $urandom; ls_wdata = $urandom; if_addr = $urandom;
    ls_at = -1; if_at = -1; nls = 0; nif = 0; nerr = 0;
    for (int c = 1; c <= 20; c++) begin
      if (if_at < 0) chk("dual_if_ready", if_ready, 0);
      if (ls_at > 0 && c == ls_at + 1) chk("dual_ls_ready", ls_ready, 1);
      if (ls_valid) begin nls++; ls_at = c; chk("dual_ls_rdata", ls_rdata, 0); last_ls = 32'd0; end
      if (if_valid) begin nif++; if_at = c; chk("dual_if_rdata", if_rdata, 32'h00A00093); last_if = 32'h00A00093; end
      if (ls_err || if_err) nerr++;
      @(negedge clk);
    end
    chk("dual_ls_cycle", ls_at, 2 + 2);
    chk("dual_if_cycle", if_at, (2 + 2) + 3 + 2);
    chk("dual_pulses", {nls[7:0], nif[7:0], nerr[7:0]}, 24'h010100);
    chk("dual_req_count", log_addr.size() - base, 2);
    if (log_addr.size() >= base + 2) begin
      chk("dual_req0", {log_rw[base], log_sz[base]}, 3'b110);
      chk("dual_req0_addr", log_addr[base], 32'h200);
      chk("dual_req0_wd", log_wd[base], 32'hDEADBEEF);
      chk("dual_req1", {log_rw[base+1], log_sz[base+1]}, 3'b010);
      chk("dual_req1_addr", log_addr[base+1], 32'h300);
    end

    // Reset during WAIT, then a stray data_valid must be ignored.
    ctl_lat  = 10;
    ctl_data = 32'h55;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h108;
    @(negedge clk);
    ls_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    last_ls = 32'd0;
    last_if = 32'd0;
    chk("rr_ready", {ls_ready, if_ready}, 2'b11);
    chk("rr_addr", mb.mem_address, 0);
    chk("rr_ctl", {mb.mem_rw_req, mb.mem_rw, mb.mem_size}, 0);
    chk("rr_wdata", mb.mem_write_data, 0);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (ls_valid || ls_err || if_valid || if_err) pulses++;
      @(negedge clk);
    end
    chk("rr_no_pulse", pulses, 0);
    chk("rr_rdata", ls_rdata, 0);
    chk("rr_ready_end", {ls_ready, if_ready}, 2'b11);
    txn(1, 0, 3'b000, 32'h10C, 32'd0, 32'h00000080);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom);
      f3   = 3'($urandom);
      addr = $urandom_range(0, 32'hFFFF);
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) addr = 32'h10000 + $urandom_range(0, 32'hFFFF);
      txn(1, we, f3, addr, $urandom, $urandom);
    end
    for (int i = 0; i < 12; i++) begin
      addr = $urandom_range(0, 32'hFFFF);
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      txn(0, 0, 3'b000, addr, 32'd0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
